// File: rtl/core_pkg.sv
// core_pkg: shared widths, ALU Card codes and the ID/EX slot record for the RV32 core.
package core_pkg;
  localparam int XLEN = 32;
  localparam int CARD_W = 5;
  localparam int REG_W = 5;
  typedef logic [XLEN-1:0] word_t;
  typedef logic [CARD_W-1:0] card_t;
  typedef logic [REG_W-1:0] reg_t;
  localparam card_t NOP_CARD = 5'b00000;
  localparam card_t OP_1 = 5'd1;
  localparam card_t OP_2 = 5'd2;
  localparam card_t OP_3 = 5'd3;
  localparam card_t OP_4 = 5'd4;
  localparam card_t OP_5 = 5'd5;
  localparam card_t OP_6 = 5'd6;
  localparam card_t OP_7 = 5'd7;
  localparam card_t OP_8 = 5'd8;
  localparam card_t OP_9 = 5'd9;
  localparam card_t OP_10 = 5'd10;
  localparam card_t OP_11 = 5'd11;
  localparam card_t OP_12 = 5'd12;
  localparam card_t OP_13 = 5'd13;
  localparam card_t OP_14 = 5'd14;
  localparam card_t OP_15 = 5'd15;
  localparam card_t OP_16 = 5'd16;
  typedef struct packed {
    logic  valid;
    word_t pc;
    word_t rs1_data;
    word_t rs2_data;
    word_t imm;
    reg_t  rs1_addr;
    reg_t  rs2_addr;
    reg_t  rd;
    card_t card;
    logic  cin;
    logic  use_pc;
    logic  use_imm;
    logic  reg_write;
    logic  mem_read;
    logic  mem_write;
  } ex_slot_t;
  // x0 is hardwired zero, so a write to it must never be forwarded
  function automatic logic fwd_hit(input logic we, input reg_t rd, input reg_t rs);
    return we && (rd != '0) && (rd == rs);
  endfunction
endpackage

// File: rtl/ex_operand_stage_if.sv
// ex_operand_stage_if: ID fields, pipeline control, bypass sources and ALU/EX outputs of the operand stage.
interface ex_operand_stage_if;
  import core_pkg::*;
  logic  id_valid;
  word_t id_pc;
  word_t id_rs1_data;
  word_t id_rs2_data;
  word_t id_imm;
  reg_t  id_rs1_addr;
  reg_t  id_rs2_addr;
  reg_t  id_rd_addr;
  card_t id_card;
  logic  id_cin;
  logic  id_use_pc;
  logic  id_use_imm;
  logic  id_reg_write;
  logic  id_mem_read;
  logic  id_mem_write;
  logic  stall_in;
  logic  flush_in;
  reg_t  exmem_rd;
  logic  exmem_reg_write;
  word_t exmem_result;
  reg_t  memwb_rd;
  logic  memwb_reg_write;
  word_t memwb_result;
  word_t alu_a;
  word_t alu_b;
  logic  alu_cin;
  card_t alu_card;
  logic  ex_valid;
  word_t ex_pc;
  reg_t  ex_rd_addr;
  logic  ex_reg_write;
  logic  ex_mem_read;
  logic  ex_mem_write;
  word_t ex_store_data;
  logic  id_hold;
  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1_addr, id_rs2_addr, id_rd_addr,
           id_card, id_cin, id_use_pc, id_use_imm, id_reg_write, id_mem_read, id_mem_write,
           stall_in, flush_in, exmem_rd, exmem_reg_write, exmem_result, memwb_rd, memwb_reg_write, memwb_result,
    input  alu_a, alu_b, alu_cin, alu_card, ex_valid, ex_pc, ex_rd_addr, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_store_data, id_hold
  );
  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1_addr, id_rs2_addr, id_rd_addr,
           id_card, id_cin, id_use_pc, id_use_imm, id_reg_write, id_mem_read, id_mem_write,
           stall_in, flush_in, exmem_rd, exmem_reg_write, exmem_result, memwb_rd, memwb_reg_write, memwb_result,
    output alu_a, alu_b, alu_cin, alu_card, ex_valid, ex_pc, ex_rd_addr, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_store_data, id_hold
  );
endinterface

// File: rtl/ex_operand_stage_fwd_mux.sv
// fwd_mux: priority bypass select for one operand; the youngest producer (EX/MEM) wins over MEM/WB.
module fwd_mux
  import core_pkg::*;
(
  input  reg_t  rs,
  input  word_t rf_data,
  input  logic  exmem_we,
  input  reg_t  exmem_rd,
  input  word_t exmem_res,
  input  logic  memwb_we,
  input  reg_t  memwb_rd,
  input  word_t memwb_res,
  output word_t data
);
  assign data = fwd_hit(exmem_we, exmem_rd, rs) ? exmem_res :
                fwd_hit(memwb_we, memwb_rd, rs) ? memwb_res : rf_data;
endmodule

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX register with load-use bubble insertion and forwarded ALU operands.
module ex_operand_stage
  import core_pkg::*;
(
  input logic clk,
  input logic rst_n,
  ex_operand_stage_if.slave bus
);
  localparam ex_slot_t BUBBLE = '{card: NOP_CARD, default: '0};
  ex_slot_t slot_q, slot_d, id_slot, held;
  word_t fwd_rs1, fwd_rs2;
  logic id_hold;
  fwd_mux u_fwd_rs1 (
    .rs(slot_q.rs1_addr), .rf_data(slot_q.rs1_data),
    .exmem_we(bus.exmem_reg_write), .exmem_rd(bus.exmem_rd), .exmem_res(bus.exmem_result),
    .memwb_we(bus.memwb_reg_write), .memwb_rd(bus.memwb_rd), .memwb_res(bus.memwb_result),
    .data(fwd_rs1)
  );
  fwd_mux u_fwd_rs2 (
    .rs(slot_q.rs2_addr), .rf_data(slot_q.rs2_data),
    .exmem_we(bus.exmem_reg_write), .exmem_rd(bus.exmem_rd), .exmem_res(bus.exmem_result),
    .memwb_we(bus.memwb_reg_write), .memwb_rd(bus.memwb_rd), .memwb_res(bus.memwb_result),
    .data(fwd_rs2)
  );
  always_comb begin
    id_hold = slot_q.valid && slot_q.mem_read && (slot_q.rd != '0) &&
              ((slot_q.rd == bus.id_rs1_addr) || (slot_q.rd == bus.id_rs2_addr)) &&
              bus.id_valid && !bus.flush_in;
    id_slot = '{valid: 1'b1, pc: bus.id_pc, rs1_data: bus.id_rs1_data, rs2_data: bus.id_rs2_data,
                imm: bus.id_imm, rs1_addr: bus.id_rs1_addr, rs2_addr: bus.id_rs2_addr,
                rd: bus.id_rd_addr, card: bus.id_card, cin: bus.id_cin, use_pc: bus.id_use_pc,
                use_imm: bus.id_use_imm, reg_write: bus.id_reg_write, mem_read: bus.id_mem_read,
                mem_write: bus.id_mem_write};
    // a held slot re-latches its bypassed operands so a producer retiring during the stall is kept
    held = slot_q;
    held.rs1_data = fwd_rs1;
    held.rs2_data = fwd_rs2;
    slot_d = bus.flush_in ? BUBBLE :
             bus.stall_in ? held :
             (id_hold || !bus.id_valid) ? BUBBLE : id_slot;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) slot_q <= BUBBLE;
    else slot_q <= slot_d;
  end
  assign bus.alu_a = slot_q.use_pc ? slot_q.pc : fwd_rs1;
  assign bus.alu_b = slot_q.use_imm ? slot_q.imm : fwd_rs2;
  assign bus.alu_cin = slot_q.cin;
  assign bus.alu_card = slot_q.card;
  assign bus.ex_valid = slot_q.valid;
  assign bus.ex_pc = slot_q.pc;
  assign bus.ex_rd_addr = slot_q.rd;
  assign bus.ex_reg_write = slot_q.valid & slot_q.reg_write;
  assign bus.ex_mem_read = slot_q.valid & slot_q.mem_read;
  assign bus.ex_mem_write = slot_q.valid & slot_q.mem_write;
  assign bus.ex_store_data = fwd_rs2;
  assign bus.id_hold = id_hold;
endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: vector table, directed hazard/stall/flush/reset sequences and a random run vs. an instruction-level model.
module tb_ex_operand_stage;
  import core_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  ex_operand_stage_if bus ();
  ex_operand_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic valid;
    word_t pc, rs1v, rs2v, imm;
    reg_t rs1, rs2, rd;
    card_t card;
    logic cin, use_pc, use_imm, rw, mr, mw;
  } instr_t;
  typedef struct {
    reg_t rs;
    word_t rf;
    reg_t ex_rd;
    logic ex_we;
    reg_t wb_rd;
    logic wb_we;
    word_t exp;
  } fwd_vec_t;
  instr_t m, nxt, empty;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic word_t fwd(input reg_t rs, input word_t rf);
    if (rs == 0) return rf;
    if (bus.exmem_reg_write && bus.exmem_rd == rs) return bus.exmem_result;
    if (bus.memwb_reg_write && bus.memwb_rd == rs) return bus.memwb_result;
    return rf;
  endfunction
  function automatic logic hazard();
    return m.valid && m.mr && m.rd != 0 && (m.rd == bus.id_rs1_addr || m.rd == bus.id_rs2_addr)
           && bus.id_valid && !bus.flush_in;
  endfunction
  function automatic instr_t model_next();
    instr_t n;
    n = m;
    if (bus.flush_in) return empty;
    if (bus.stall_in) begin
      n.rs1v = fwd(m.rs1, m.rs1v);
      n.rs2v = fwd(m.rs2, m.rs2v);
      return n;
    end
    if (hazard() || !bus.id_valid) return empty;
    n = '{valid: 1'b1, pc: bus.id_pc, rs1v: bus.id_rs1_data, rs2v: bus.id_rs2_data, imm: bus.id_imm,
          rs1: bus.id_rs1_addr, rs2: bus.id_rs2_addr, rd: bus.id_rd_addr, card: bus.id_card,
          cin: bus.id_cin, use_pc: bus.id_use_pc, use_imm: bus.id_use_imm, rw: bus.id_reg_write,
          mr: bus.id_mem_read, mw: bus.id_mem_write};
    return n;
  endfunction
  task automatic check_model(input string tag);
    chk({tag, " ex_valid"}, 32'(bus.ex_valid), 32'(m.valid));
    chk({tag, " id_hold"}, 32'(bus.id_hold), 32'(hazard()));
    chk({tag, " alu_card"}, 32'(bus.alu_card), 32'(m.valid ? m.card : NOP_CARD));
    chk({tag, " ex_reg_write"}, 32'(bus.ex_reg_write), 32'(m.valid & m.rw));
    chk({tag, " ex_mem_read"}, 32'(bus.ex_mem_read), 32'(m.valid & m.mr));
    chk({tag, " ex_mem_write"}, 32'(bus.ex_mem_write), 32'(m.valid & m.mw));
    if (m.valid) begin
      chk({tag, " alu_a"}, bus.alu_a, m.use_pc ? m.pc : fwd(m.rs1, m.rs1v));
      chk({tag, " alu_b"}, bus.alu_b, m.use_imm ? m.imm : fwd(m.rs2, m.rs2v));
      chk({tag, " store"}, bus.ex_store_data, fwd(m.rs2, m.rs2v));
      chk({tag, " alu_cin"}, 32'(bus.alu_cin), 32'(m.cin));
      chk({tag, " ex_pc"}, bus.ex_pc, m.pc);
      chk({tag, " ex_rd"}, 32'(bus.ex_rd_addr), 32'(m.rd));
    end
  endtask
  task automatic tick();
    nxt = model_next();
    @(posedge clk);
    #1;
    m = nxt;
  endtask
  task automatic idle_id();
    bus.id_valid = 0; bus.id_pc = 0; bus.id_rs1_data = 0; bus.id_rs2_data = 0; bus.id_imm = 0;
    bus.id_rs1_addr = 0; bus.id_rs2_addr = 0; bus.id_rd_addr = 0; bus.id_card = NOP_CARD;
    bus.id_cin = 0; bus.id_use_pc = 0; bus.id_use_imm = 0; bus.id_reg_write = 0;
    bus.id_mem_read = 0; bus.id_mem_write = 0;
  endtask
  task automatic idle_all();
    idle_id();
    bus.stall_in = 0; bus.flush_in = 0;
    bus.exmem_rd = 0; bus.exmem_reg_write = 0; bus.exmem_result = 0;
    bus.memwb_rd = 0; bus.memwb_reg_write = 0; bus.memwb_result = 0;
  endtask
  task automatic id_alu(input reg_t rs1, input reg_t rs2, input reg_t rd, input word_t d1, input word_t d2,
                        input card_t card);
    idle_id();
    bus.id_valid = 1; bus.id_pc = 32'h100 + 32'(rd); bus.id_rs1_addr = rs1; bus.id_rs2_addr = rs2;
    bus.id_rd_addr = rd; bus.id_rs1_data = d1; bus.id_rs2_data = d2; bus.id_card = card;
    bus.id_reg_write = 1;
  endtask
  fwd_vec_t vecs[7];
  initial begin
    empty = '{default: '0};
    m = empty;
    vecs[0] = '{5, 32'h1111, 5, 1, 5, 1, 32'hAAAA_0000};
    vecs[1] = '{5, 32'h1111, 5, 0, 5, 1, 32'h0000_1234};
    vecs[2] = '{5, 32'h1111, 5, 0, 5, 0, 32'h0000_1111};
    vecs[3] = '{0, 32'h0000, 0, 1, 0, 1, 32'h0000_0000};
    vecs[4] = '{5, 32'h1111, 6, 1, 5, 1, 32'h0000_1234};
    vecs[5] = '{5, 32'h1111, 5, 1, 6, 1, 32'hAAAA_0000};
    vecs[6] = '{3, 32'h3333, 6, 1, 7, 1, 32'h0000_3333};
    idle_all();
    // reset state
    #2;
    check_model("reset");
    chk("reset alu_a", bus.alu_a, 0);
    chk("reset alu_b", bus.alu_b, 0);
    #1 rst_n = 1;
    tick();
    check_model("idle");
    chk("idle alu_card", 32'(bus.alu_card), 0);
    // basic capture
    id_alu(1, 2, 3, 32'h10, 32'h20, OP_1);
    tick();
    idle_id();
    #1;
    chk("basic alu_a", bus.alu_a, 32'h10);
    chk("basic alu_b", bus.alu_b, 32'h20);
    chk("basic card", 32'(bus.alu_card), 32'd1);
    chk("basic valid", 32'(bus.ex_valid), 1);
    check_model("basic");
    // forwarding priority table
    foreach (vecs[i]) begin
      id_alu(vecs[i].rs, vecs[i].rs, 4, vecs[i].rf, vecs[i].rf, OP_2);
      bus.id_use_imm = 1; bus.id_imm = 32'h55;
      tick();
      idle_id();
      bus.exmem_rd = vecs[i].ex_rd; bus.exmem_reg_write = vecs[i].ex_we; bus.exmem_result = 32'hAAAA_0000;
      bus.memwb_rd = vecs[i].wb_rd; bus.memwb_reg_write = vecs[i].wb_we; bus.memwb_result = 32'h1234;
      #1;
      chk($sformatf("vec%0d alu_a", i), bus.alu_a, vecs[i].exp);
      chk($sformatf("vec%0d store", i), bus.ex_store_data, vecs[i].exp);
      chk($sformatf("vec%0d alu_b", i), bus.alu_b, 32'h55);
      check_model($sformatf("vec%0d", i));
      idle_all();
    end
    // load-use: load x7 in EX, dependent reads rs2=7
    id_alu(1, 2, 7, 32'h0, 32'h0, OP_1);
    bus.id_mem_read = 1;
    tick();
    id_alu(3, 7, 8, 32'h30, 32'h40, OP_3);
    #1;
    chk("lu hold", 32'(bus.id_hold), 1);
    check_model("lu0");
    tick();
    #1;
    chk("lu bubble valid", 32'(bus.ex_valid), 0);
    chk("lu bubble rw", 32'(bus.ex_reg_write), 0);
    chk("lu bubble card", 32'(bus.alu_card), 32'(NOP_CARD));
    chk("lu hold drops", 32'(bus.id_hold), 0);
    check_model("lu1");
    tick();
    idle_id();
    bus.memwb_rd = 7; bus.memwb_reg_write = 1; bus.memwb_result = 32'hCAFE_F00D;
    #1;
    chk("lu enter valid", 32'(bus.ex_valid), 1);
    chk("lu enter alu_a", bus.alu_a, 32'h30);
    chk("lu enter alu_b", bus.alu_b, 32'hCAFE_F00D);
    chk("lu enter store", bus.ex_store_data, 32'hCAFE_F00D);
    check_model("lu2");
    idle_all();
    // stall: producer visible only in the first held cycle
    id_alu(9, 0, 10, 32'h1, 32'h0, OP_4);
    tick();
    id_alu(11, 12, 13, 32'h77, 32'h88, OP_6);
    bus.stall_in = 1;
    bus.memwb_rd = 9; bus.memwb_reg_write = 1; bus.memwb_result = 32'hDEAD;
    #1;
    chk("stall c1 alu_a", bus.alu_a, 32'hDEAD);
    tick();
    bus.memwb_reg_write = 0; bus.memwb_result = 0;
    #1;
    check_model("stall c2");
    tick();
    tick();
    bus.stall_in = 0;
    idle_id();
    #1;
    chk("stall release alu_a", bus.alu_a, 32'hDEAD);
    chk("stall rd held", 32'(bus.ex_rd_addr), 10);
    check_model("stall rel");
    tick();
    // flush beats stall
    id_alu(1, 2, 3, 32'h5, 32'h6, OP_5);
    bus.stall_in = 1; bus.flush_in = 1;
    tick();
    idle_all();
    #1;
    chk("flush valid", 32'(bus.ex_valid), 0);
    chk("flush rw", 32'(bus.ex_reg_write), 0);
    chk("flush card", 32'(bus.alu_card), 32'(NOP_CARD));
    check_model("flush");
    // asynchronous reset mid-stream
    id_alu(4, 5, 6, 32'h44, 32'h55, OP_5);
    bus.id_cin = 1;
    tick();
    idle_id();
    #1;
    chk("pre-rst valid", 32'(bus.ex_valid), 1);
    rst_n = 0;
    #1;
    m = empty;
    chk("arst valid", 32'(bus.ex_valid), 0);
    chk("arst card", 32'(bus.alu_card), 32'(NOP_CARD));
    chk("arst cin", 32'(bus.alu_cin), 0);
    chk("arst alu_a", bus.alu_a, 0);
    chk("arst pc", bus.ex_pc, 0);
    chk("arst rw", 32'(bus.ex_reg_write), 0);
    #1 rst_n = 1;
    tick();
    // random traffic
    for (int c = 0; c < 500; c++) begin
      bus.id_valid = ($urandom_range(0, 9) < 8);
      bus.id_pc = $urandom; bus.id_rs1_data = $urandom; bus.id_rs2_data = $urandom; bus.id_imm = $urandom;
      bus.id_rs1_addr = reg_t'($urandom_range(0, 7)); bus.id_rs2_addr = reg_t'($urandom_range(0, 7));
      bus.id_rd_addr = reg_t'($urandom_range(0, 7)); bus.id_card = card_t'($urandom_range(0, 16));
      bus.id_cin = 1'($urandom); bus.id_use_pc = 1'($urandom); bus.id_use_imm = 1'($urandom);
      bus.id_reg_write = 1'($urandom); bus.id_mem_read = ($urandom_range(0, 9) < 3);
      bus.id_mem_write = 1'($urandom);
      bus.stall_in = ($urandom_range(0, 9) < 2); bus.flush_in = ($urandom_range(0, 9) < 1);
      bus.exmem_rd = reg_t'($urandom_range(0, 7)); bus.exmem_reg_write = 1'($urandom); bus.exmem_result = $urandom;
      bus.memwb_rd = reg_t'($urandom_range(0, 7)); bus.memwb_reg_write = 1'($urandom); bus.memwb_result = $urandom;
      #1;
      check_model($sformatf("rnd%0d", c));
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
ID/EX pipeline register plus operand-forwarding front end that feeds the ALU (A, B, Cin, Card) in the 5-stage RV32 core. It captures decoded fields from ID and resolves RAW hazards from EX/MEM and MEM/WB. It detects load-use hazards and inserts bubbles. Its outputs drive the ALU ports directly, and it passes control and store data toward EX/MEM.

Parameters:
XLEN, 32, datapath width
CARD_W, 5, ALU operation-code width
NOP_CARD, 5'b00000, Card value driven for bubbles and after reset

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_pc  in  XLEN  instruction PC
id_rs1_data, id_rs2_data  in  XLEN  register-file read data
id_imm  in  XLEN  sign-extended immediate
id_rs1_addr, id_rs2_addr, id_rd_addr  in  5  register indices
id_card  in  CARD_W  ALU operation code
id_cin  in  1  ALU carry-in
id_use_pc  in  1  A operand = PC
id_use_imm  in  1  B operand = immediate
id_reg_write, id_mem_read, id_mem_write  in  1  control bits
stall_in  in  1  downstream hold (MEM busy)
flush_in  in  1  branch/jump squash
exmem_rd  in  5  EX/MEM destination
exmem_reg_write  in  1  EX/MEM writes rd
exmem_result  in  XLEN  EX/MEM ALU result
memwb_rd  in  5  MEM/WB destination
memwb_reg_write  in  1  MEM/WB writes rd
memwb_result  in  XLEN  MEM/WB writeback value
alu_a, alu_b  out  XLEN  ALU operands
alu_cin  out  1  ALU Cin
alu_card  out  CARD_W  ALU Card
ex_valid  out  1  EX slot holds a real instruction
ex_pc  out  XLEN  registered PC
ex_rd_addr  out  5  registered rd
ex_reg_write, ex_mem_read, ex_mem_write  out  1  gated control (0 when !ex_valid)
ex_store_data  out  XLEN  forwarded rs2 value
id_hold  out  1  load-use stall request to IF/ID

Behaviour:
- Reset (async, rst_n=0): all registers cleared. ex_valid=0, alu_card=NOP_CARD, alu_cin=0, and all data and control outputs 0.
- Register update priority per rising edge:
  1. flush_in: ex_valid←0, control←0, card←NOP_CARD.
  2. Else stall_in: hold all fields. rs1/rs2 data registers reload with their current forwarded values, so a producer retiring during the hold is not lost.
  3. Else id_hold: insert bubble, same as flush.
  4. Else: capture all id_* fields, and ex_valid←id_valid.
- Load-use detection (combinational): id_hold = ex_valid & ex_mem_read & ex_rd_addr≠0 & (ex_rd_addr==id_rs1_addr | ex_rd_addr==id_rs2_addr) & id_valid & !flush_in. The hold lasts exactly one cycle per hazard.
- Forwarding (combinational on registered rs indices, per operand):
  - EX/MEM match (reg_write, rd≠0, rd==rs) wins.
  - Else MEM/WB match.
  - Else registered register-file data.
  - x0 never forwards.
- alu_a = use_pc ? ex_pc : fwd_rs1.
- alu_b = use_imm ? imm : fwd_rs2.
- ex_store_data = fwd_rs2 always, independent of use_imm.
- alu_card and alu_cin are direct register outputs: zero combinational path from id_*.
- Latency: one cycle ID→ALU inputs. Forward paths are zero-cycle from exmem/memwb inputs.
- Bubble: ex_valid=0 forces alu_card=NOP_CARD and all write/mem controls to 0. Data fields are don't-care but must be deterministic (held at 0).
- Simultaneous flush_in and stall_in: flush wins.
- id_hold while flush_in: suppressed.

Decomposition:
- Shared package (core_pkg): XLEN, CARD_W, register-index width, NOP_CARD, and the OP_1..OP_16 Card constants used by the ALU.
- One sub-module, fwd_mux: pure combinational priority select for one operand. Instantiated twice (rs1, rs2).

Test Plan:
1. Reset then rst_n=1, no id_valid → ex_valid=0, alu_card=5'b00000, alu_a=alu_b=0.
2. id_rs1_data=0x10, id_rs2_data=0x20, id_card=OP_1, valid, no matches → next cycle alu_a=0x10, alu_b=0x20, alu_card=5'b00001, ex_valid=1.
3. ex rs1=5 with exmem_rd=5 (0xAAAA_0000) and memwb_rd=5 (0x1234) both writing → alu_a=0xAAAA_0000. Drop exmem_reg_write → alu_a=0x1234. With rs1=0 → no forward.
4. Load to x7 in EX, ID reads rs2=7 → id_hold=1 for one cycle, next ex_valid=0 with controls 0, then the instruction enters with memwb_result forwarded.
5. stall_in=1 for 3 cycles, memwb_rd matches rs1 with 0xDEAD only in cycle 1 → after release alu_a still 0xDEAD.
6. flush_in=1 with stall_in=1 and valid ID → next ex_valid=0, ex_reg_write=0, alu_card=NOP_CARD. Assert rst_n=0 mid-stream → outputs clear immediately, without waiting for a clock edge.
